amns_limb_collector: RTL and testbench
======================================

Name: amns_limb_collector

Overview:
- Receiving end of the PE chain's result path. Captures the 17-bit low limbs shifted out of the Montgomery PE array, least-significant first, then the signed 48-bit high word (RES of the last PE).
- Reassembles them into one signed AMNS coefficient and presents it with a valid/ready handshake to the downstream coefficient store.
- Sits between the PE array and the result RAM/output serializer. One instance per coefficient lane.

Parameters:
- LIMB_W, 17, width of one limb; matches the PE DSP B-port data width.
- N_LIMBS, 4, number of low limbs per coefficient.
- HI_W, 48, width of the final high word; matches DSP P width.
- COEF_W, LIMB_W*N_LIMBS+HI_W, output coefficient width (derived; do not override).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  arms collection for one coefficient; honoured only in IDLE.
- limb_valid_i  in  1  limb_i holds a valid low limb this cycle.
- limb_i  in  LIMB_W  unsigned low limb (PE C_reg low output).
- hi_valid_i  in  1  hi_i holds the final high word this cycle.
- hi_i  in  HI_W  signed high word (two's complement).
- busy_o  out  1  high in COLLECT, HIGH and DONE.
- coef_valid_o  out  1  coef_o valid.
- coef_ready_i  in  1  downstream accepts coef_o.
- coef_o  out  COEF_W  signed reassembled coefficient.
- limb_cnt_o  out  clog2(N_LIMBS+1)  number of limbs captured so far.
- overrun_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, coef_o=0, coef_valid_o=0, busy_o=0, limb_cnt_o=0, overrun_o=0.
- IDLE: start_i=1 -> COLLECT, limb_cnt=0, shift register cleared. limb_valid_i and hi_valid_i are ignored.
- COLLECT: each limb_valid_i=1 writes limb_i into field [LIMB_W*k +: LIMB_W] with k=limb_cnt, then increments limb_cnt. On the N_LIMBS-th limb -> HIGH.
- COLLECT errors: hi_valid_i=1 sets overrun_o and is dropped. If limb_valid_i and hi_valid_i arrive in the same cycle, the limb is taken and overrun_o is set.
- HIGH: hi_valid_i=1 writes hi_i into coef_o[COEF_W-1 -: HI_W] unmodified (sign is carried by the top field). Next cycle coef_valid_o=1, state=DONE.
- HIGH errors: limb_valid_i=1 sets overrun_o and is dropped.
- Latency: coef_valid_o rises exactly 1 cycle after the cycle in which hi_valid_i is accepted.
- DONE: coef_o and coef_valid_o are held stable until coef_valid_o & coef_ready_i. On the handshake cycle -> IDLE, coef_valid_o=0 next cycle, limb_cnt=0.
- DONE errors: the PE chain cannot stall, so limb_valid_i or hi_valid_i in DONE sets overrun_o and the data is dropped. coef_o is never corrupted.
- start_i while not IDLE: ignored, no error.
- start_i in the same cycle as the DONE handshake: ignored. start is re-issued after return to IDLE, so there is a minimum 1 idle cycle between coefficients.
- overrun_o clears only on reset_i.
- Reset asserted mid-operation (any state): immediate return to reset values; partial limbs are discarded.
- No arithmetic carry resolution. Limbs are unsigned and non-overlapping, so concatenation is exact: value = sum(limb_k*2^(17k)) + hi*2^(17*N_LIMBS).

Test Plan:
- N_LIMBS=4. start, then limbs 0x00001, 0x00002, 0x00003, 0x00004 on consecutive cycles, then hi=0x0, coef_ready_i=1 -> coef_o = 1 + 2<<17 + 3<<34 + 4<<51. coef_valid_o rises 1 cycle after hi, is high for 1 cycle, then IDLE.
- Same limbs with hi=48'hFFFF_FFFF_FFFF (-1), coef_ready_i=0 for 5 cycles -> coef_o top 48 bits all ones, low 68 bits as above. Value stable and coef_valid_o held 5 cycles. Handshake on cycle 6, then IDLE.
- Limbs arriving with gaps (limb_valid_i toggling 1,0,0,1,1,0,1) -> limb_cnt_o steps 1..4 only on valid cycles. Result identical to the first scenario.
- hi_valid_i after only 2 limbs -> overrun_o=1 sticky, state stays COLLECT. The remaining 2 limbs plus hi still produce the correct coef_o.
- Extra limb_valid_i while in DONE with coef_ready_i=0 -> overrun_o=1, coef_o unchanged.
- reset_i pulsed asynchronously (not on a clock edge) after 3 limbs -> all outputs 0 immediately. A fresh start plus 4 limbs plus hi gives the correct result with no residue from the aborted run.

Source files
------------

// File: rtl/amns_limb_collector.sv
// amns_limb_collector
// Reassembles one signed AMNS coefficient from the PE chain result path:
// N_LIMBS unsigned low limbs (least-significant first) followed by one
// signed high word, then offers it downstream with a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; limb/hi strobes ignored
// COLLECT | capturing low limbs into the slot selected by limb_cnt
// HIGH    | all low limbs held, waiting for the high word
// DONE    | coefficient valid, held until coef_ready_i handshake
module amns_limb_collector #(
    parameter  int LIMB_W  = 17,
    parameter  int N_LIMBS = 4,
    parameter  int HI_W    = 48,
    localparam int COEF_W  = LIMB_W * N_LIMBS + HI_W,
    localparam int CNT_W   = $clog2(N_LIMBS + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              limb_valid_i,
    input  logic [LIMB_W-1:0] limb_i,
    input  logic              hi_valid_i,
    input  logic [HI_W-1:0]   hi_i,
    output logic              busy_o,
    output logic              coef_valid_o,
    input  logic              coef_ready_i,
    output logic [COEF_W-1:0] coef_o,
    output logic [CNT_W-1:0]  limb_cnt_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HIGH    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(N_LIMBS - 1);

    state_t                     r_state;
    logic [LIMB_W*N_LIMBS-1:0]  r_limbs;
    logic [HI_W-1:0]            r_hi;
    logic [CNT_W-1:0]           r_limb_cnt;
    logic                       r_coef_valid;
    logic                       r_overrun;

    state_t w_next_state;
    logic   w_clear;
    logic   w_limb_take;
    logic   w_hi_take;
    logic   w_handshake;
    logic   w_err;

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle capture/error strobes.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_limb_take  = 1'b0;
        w_hi_take    = 1'b0;
        w_handshake  = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_clear      = 1'b1;
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A high word here is early: flag it, but a coincident limb is still taken.
                if (limb_valid_i) begin
                    w_limb_take = 1'b1;
                    if (r_limb_cnt == LAST_LIMB) begin
                        w_next_state = S_HIGH;
                    end
                end
                if (hi_valid_i) begin
                    w_err = 1'b1;
                end
            end
            S_HIGH: begin
                if (hi_valid_i) begin
                    w_hi_take    = 1'b1;
                    w_next_state = S_DONE;
                end
                if (limb_valid_i) begin
                    w_err = 1'b1;
                end
            end
            S_DONE: begin
                // The PE chain cannot be stalled, so anything arriving now is lost.
                if (limb_valid_i || hi_valid_i) begin
                    w_err = 1'b1;
                end
                if (r_coef_valid && coef_ready_i) begin
                    w_handshake  = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Coefficient datapath, limb counter, valid flag and sticky overrun.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_limbs      <= '0;
            r_hi         <= '0;
            r_limb_cnt   <= '0;
            r_coef_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_clear) begin
                r_limbs    <= '0;
                r_hi       <= '0;
                r_limb_cnt <= '0;
            end
            if (w_limb_take) begin
                for (int k = 0; k < N_LIMBS; k++) begin
                    if (r_limb_cnt == CNT_W'(k)) begin
                        r_limbs[k*LIMB_W +: LIMB_W] <= limb_i;
                    end
                end
                r_limb_cnt <= r_limb_cnt + CNT_W'(1);
            end
            if (w_hi_take) begin
                r_hi         <= hi_i;
                r_coef_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_coef_valid <= 1'b0;
                r_limb_cnt   <= '0;
            end
            if (w_err) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Limbs are unsigned and non-overlapping, so plain concatenation is exact.
    assign coef_o       = {r_hi, r_limbs};
    assign coef_valid_o = r_coef_valid;
    assign busy_o       = (r_state != S_IDLE);
    assign limb_cnt_o   = r_limb_cnt;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_amns_limb_collector.sv
// Testbench for amns_limb_collector: scoreboard of expected coefficients,
// pushed when the high word is driven and popped on each output handshake.
module tb_amns_limb_collector;

    localparam int LIMB_W  = 17;
    localparam int N_LIMBS = 4;
    localparam int HI_W    = 48;
    localparam int COEF_W  = LIMB_W * N_LIMBS + HI_W;
    localparam int CNT_W   = $clog2(N_LIMBS + 1);

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              start_i = 1'b0;
    logic              limb_valid_i = 1'b0;
    logic [LIMB_W-1:0] limb_i = '0;
    logic              hi_valid_i = 1'b0;
    logic [HI_W-1:0]   hi_i = '0;
    logic              busy_o;
    logic              coef_valid_o;
    logic              coef_ready_i = 1'b0;
    logic [COEF_W-1:0] coef_o;
    logic [CNT_W-1:0]  limb_cnt_o;
    logic              overrun_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] sb_q[$];

    amns_limb_collector #(
        .LIMB_W (LIMB_W),
        .N_LIMBS(N_LIMBS),
        .HI_W   (HI_W)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .limb_valid_i(limb_valid_i),
        .limb_i      (limb_i),
        .hi_valid_i  (hi_valid_i),
        .hi_i        (hi_i),
        .busy_o      (busy_o),
        .coef_valid_o(coef_valid_o),
        .coef_ready_i(coef_ready_i),
        .coef_o      (coef_o),
        .limb_cnt_o  (limb_cnt_o),
        .overrun_o   (overrun_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: compare on every accepted output.
    always @(negedge clock_i) begin
        if (!reset_i && coef_valid_o && coef_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 128'(coef_o), 128'hDEAD);
            end else begin
                chk("sb_coef", 128'(coef_o), sb_q.pop_front());
            end
        end
    end

    function automatic logic [127:0] mk(input logic [HI_W-1:0] h, input logic [LIMB_W-1:0] a,
                                        input logic [LIMB_W-1:0] b, input logic [LIMB_W-1:0] c,
                                        input logic [LIMB_W-1:0] d);
        logic [127:0] v;
        v = 128'(a) + (128'(b) << 17) + (128'(c) << 34) + (128'(d) << 51) + (128'(h) << 68);
        return v;
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_busy", 128'(busy_o), 128'(1));
        chk("start_cnt", 128'(limb_cnt_o), 128'(0));
    endtask

    task automatic send_limb(input logic [LIMB_W-1:0] v, input int cnt_after);
        limb_valid_i = 1'b1;
        limb_i       = v;
        step();
        limb_valid_i = 1'b0;
        chk("limb_cnt", 128'(limb_cnt_o), 128'(cnt_after));
    endtask

    task automatic send_hi(input logic [HI_W-1:0] h, input logic [127:0] exp);
        chk("pre_hi_valid", 128'(coef_valid_o), 128'(0));
        sb_q.push_back(exp);
        hi_valid_i = 1'b1;
        hi_i       = h;
        step();
        hi_valid_i = 1'b0;
        chk("hi_latency_valid", 128'(coef_valid_o), 128'(1));
        chk("hi_coef", 128'(coef_o), exp);
    endtask

    // Hold ready low for `hold` cycles, then handshake (with a start that must be ignored).
    task automatic finish_coef(input int hold, input logic [127:0] exp);
        coef_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 128'(coef_valid_o), 128'(1));
            chk("hold_coef", 128'(coef_o), exp);
        end
        coef_ready_i = 1'b1;
        start_i      = 1'b1;
        step();
        coef_ready_i = 1'b0;
        start_i      = 1'b0;
        chk("post_hs_valid", 128'(coef_valid_o), 128'(0));
        chk("post_hs_busy", 128'(busy_o), 128'(0));
        chk("post_hs_cnt", 128'(limb_cnt_o), 128'(0));
        step();
    endtask

    initial begin
        logic [127:0] e;

        // Reset values
        #2 reset_i = 1'b1;
        #1;
        chk("rst_coef", 128'(coef_o), 128'(0));
        chk("rst_valid", 128'(coef_valid_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_cnt", 128'(limb_cnt_o), 128'(0));
        chk("rst_ovr", 128'(overrun_o), 128'(0));
        step();
        step();
        reset_i = 1'b0;
        step();

        // Strobes in IDLE are ignored
        limb_valid_i = 1'b1;
        hi_valid_i   = 1'b1;
        step();
        limb_valid_i = 1'b0;
        hi_valid_i   = 1'b0;
        chk("idle_ovr", 128'(overrun_o), 128'(0));
        chk("idle_busy", 128'(busy_o), 128'(0));
        chk("idle_cnt", 128'(limb_cnt_o), 128'(0));

        // Scenario 1: consecutive limbs, hi=0, ready already high
        e = 128'(1) + (128'(2) << 17) + (128'(3) << 34) + (128'(4) << 51);
        do_start();
        send_limb(17'h00001, 1);
        send_limb(17'h00002, 2);
        send_limb(17'h00003, 3);
        send_limb(17'h00004, 4);
        chk("s1_busy_high", 128'(busy_o), 128'(1));
        coef_ready_i = 1'b1;
        send_hi(48'h0, e);
        finish_coef(0, e);

        // Scenario 2: hi=-1, ready low for 5 cycles
        e = mk(48'hFFFF_FFFF_FFFF, 17'h1, 17'h2, 17'h3, 17'h4);
        do_start();
        send_limb(17'h00001, 1);
        send_limb(17'h00002, 2);
        start_i = 1'b1;
        send_limb(17'h00003, 3);
        start_i = 1'b0;
        send_limb(17'h00004, 4);
        send_hi(48'hFFFF_FFFF_FFFF, e);
        chk("s2_top_ones", 128'(coef_o[COEF_W-1 -: HI_W]), 128'(48'hFFFF_FFFF_FFFF));
        finish_coef(5, e);

        // Scenario 3: gapped limb_valid 1,0,0,1,1,0,1
        e = mk(48'h0, 17'h1, 17'h2, 17'h3, 17'h4);
        do_start();
        begin
            logic [6:0] pat;
            int         cnt;
            pat = 7'b1011001;
            cnt = 0;
            for (int i = 0; i < 7; i++) begin
                if (pat[i]) begin
                    cnt++;
                    send_limb(LIMB_W'(cnt), cnt);
                end else begin
                    step();
                    chk("gap_cnt", 128'(limb_cnt_o), 128'(cnt));
                end
            end
        end
        send_hi(48'h0, e);
        finish_coef(1, e);
        chk("s3_ovr_clean", 128'(overrun_o), 128'(0));

        // Scenario 4: early hi after 2 limbs, then simultaneous limb+hi
        e = mk(48'h1234_5678_9ABC, 17'h0ABCD, 17'h1F00F, 17'h00777, 17'h10001);
        do_start();
        send_limb(17'h0ABCD, 1);
        send_limb(17'h1F00F, 2);
        hi_valid_i = 1'b1;
        hi_i       = 48'hBAD0_BAD0_BAD0;
        step();
        hi_valid_i = 1'b0;
        chk("s4_ovr", 128'(overrun_o), 128'(1));
        chk("s4_cnt", 128'(limb_cnt_o), 128'(2));
        chk("s4_valid", 128'(coef_valid_o), 128'(0));
        hi_valid_i = 1'b1;
        send_limb(17'h00777, 3);
        hi_valid_i = 1'b0;
        send_limb(17'h10001, 4);
        send_hi(48'h1234_5678_9ABC, e);
        finish_coef(2, e);
        chk("s4_ovr_sticky", 128'(overrun_o), 128'(1));

        // Scenario 6: async reset after 3 limbs, then a clean run
        do_start();
        send_limb(17'h1AAAA, 1);
        send_limb(17'h15555, 2);
        send_limb(17'h0F0F0, 3);
        #3 reset_i = 1'b1;
        #1;
        chk("arst_coef", 128'(coef_o), 128'(0));
        chk("arst_busy", 128'(busy_o), 128'(0));
        chk("arst_cnt", 128'(limb_cnt_o), 128'(0));
        chk("arst_ovr", 128'(overrun_o), 128'(0));
        chk("arst_valid", 128'(coef_valid_o), 128'(0));
        step();
        reset_i = 1'b0;
        step();
        e = mk(48'h8000_0000_0001, 17'h1FFFF, 17'h0AAAA, 17'h00000, 17'h00F0F);
        do_start();
        send_limb(17'h1FFFF, 1);
        send_limb(17'h0AAAA, 2);
        send_limb(17'h00000, 3);
        send_limb(17'h00F0F, 4);
        send_hi(48'h8000_0000_0001, e);
        chk("s6_ovr", 128'(overrun_o), 128'(0));
        finish_coef(2, e);

        // Scenario 5: extra strobes while DONE with ready low
        e = mk(48'h0000_0000_00FF, 17'h00011, 17'h00022, 17'h00033, 17'h00044);
        do_start();
        send_limb(17'h00011, 1);
        send_limb(17'h00022, 2);
        send_limb(17'h00033, 3);
        send_limb(17'h00044, 4);
        send_hi(48'h0000_0000_00FF, e);
        limb_valid_i = 1'b1;
        limb_i       = 17'h1FFFF;
        step();
        limb_valid_i = 1'b0;
        chk("s5_ovr", 128'(overrun_o), 128'(1));
        chk("s5_coef_after_limb", 128'(coef_o), e);
        hi_valid_i = 1'b1;
        hi_i       = 48'hFFFF_0000_FFFF;
        step();
        hi_valid_i = 1'b0;
        chk("s5_coef_after_hi", 128'(coef_o), e);
        chk("s5_cnt", 128'(limb_cnt_o), 128'(4));
        finish_coef(1, e);

        chk("sb_drain", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
